// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite constants and types for the decoder/mux slice.
package ahb3lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DEF_IDLE = 2'd0,
      DEF_ERR1 = 2'd1,
      DEF_ERR2 = 2'd2
   } ahb3lite_def_state_t;

   // A single slave still needs a one-bit index register.
   function automatic int SLV_IDX_W(input int slaves);
      return (slaves > 1) ? $clog2(slaves) : 1;
   endfunction

endpackage

// File: rtl/ahb3lite_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped transfers plus error log.
module ahb3lite_default_slave
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE = 32
) (
   input  logic                  hclk_i,
   input  logic                  hreset_i,
   input  logic                  hready_i,
   input  logic                  sel_def_i,
   input  logic [1:0]            htrans_i,
   input  logic [HADDR_SIZE-1:0] haddr_i,
   input  logic                  err_clr_i,
   output logic                  hreadyout_o,
   output logic                  hresp_o,
   output logic [HADDR_SIZE-1:0] err_addr_o,
   output logic [7:0]            err_count_o
);

   ahb3lite_def_state_t   state_q;
   logic                  rdy_q;
   logic                  resp_q;
   logic [HADDR_SIZE-1:0] err_addr_q;
   logic [7:0]            err_count_q, err_count_d;
   logic                  err_start;

   // ERR1 holds HREADY low, so a new erroring transfer can only start from IDLE or ERR2.
   assign err_start = hready_i && sel_def_i && (state_q != DEF_ERR1) &&
                      ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));

   always_ff @(posedge hclk_i) begin
      if (hreset_i) begin
         state_q <= DEF_IDLE;
         rdy_q   <= 1'b1;
         resp_q  <= HRESP_OKAY;
      end else begin
         case (state_q)
            DEF_ERR1: begin
               state_q <= DEF_ERR2;
               rdy_q   <= 1'b1;
               resp_q  <= HRESP_ERROR;
            end
            default: begin
               if (err_start) begin
                  state_q <= DEF_ERR1;
                  rdy_q   <= 1'b0;
                  resp_q  <= HRESP_ERROR;
               end else begin
                  state_q <= DEF_IDLE;
                  rdy_q   <= 1'b1;
                  resp_q  <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

   always_comb begin
      err_count_d = err_count_q;
      if (err_clr_i)
         err_count_d = err_start ? 8'd1 : 8'd0;
      else if (err_start && (err_count_q != 8'hFF))
         err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge hclk_i) begin
      if (hreset_i) begin
         err_addr_q  <= '0;
         err_count_q <= '0;
      end else begin
         if (err_start)
            err_addr_q <= haddr_i;
         err_count_q <= err_count_d;
      end
   end

   assign hreadyout_o = rdy_q;
   assign hresp_o     = resp_q;
   assign err_addr_o  = err_addr_q;
   assign err_count_o = err_count_q;

endmodule

// File: rtl/ahb3lite_decoder_mux.sv
// Single-master AHB3-Lite address decoder and data-phase response multiplexer.
module ahb3lite_decoder_mux
   import ahb3lite_pkg::*;
#(
   parameter int                          HADDR_SIZE = 32,
   parameter int                          HDATA_SIZE = 32,
   parameter int                          SLAVES     = 4,
   parameter logic [SLAVES*HADDR_SIZE-1:0] SLAVE_BASE = '0,
   parameter logic [SLAVES*HADDR_SIZE-1:0] SLAVE_MASK = '0
) (
   input  logic                         HCLK,
   input  logic                         HRESET,
   input  logic [HADDR_SIZE-1:0]        HADDR,
   input  logic [1:0]                   HTRANS,
   output logic                         HREADY,
   output logic                         HRESP,
   output logic [HDATA_SIZE-1:0]        HRDATA,
   output logic [SLAVES-1:0]            s_HSEL,
   input  logic [SLAVES-1:0]            s_HREADYOUT,
   input  logic [SLAVES-1:0]            s_HRESP,
   input  logic [SLAVES*HDATA_SIZE-1:0] s_HRDATA,
   input  logic                         err_clr,
   output logic [HADDR_SIZE-1:0]        err_addr,
   output logic [7:0]                   err_count
);

   localparam int IDX_W = SLV_IDX_W(SLAVES);

   logic [IDX_W-1:0] tgt_idx;
   logic             tgt_def;
   logic [IDX_W-1:0] dsel_idx_q;
   logic             dsel_def_q;
   logic             def_rdy;
   logic             def_resp;

   // Scan downwards so the lowest matching index is the last one written.
   always_comb begin
      tgt_idx = '0;
      tgt_def = 1'b1;
      for (int i = SLAVES - 1; i >= 0; i--) begin
         if (((HADDR ^ SLAVE_BASE[i*HADDR_SIZE +: HADDR_SIZE]) &
              SLAVE_MASK[i*HADDR_SIZE +: HADDR_SIZE]) == '0) begin
            tgt_idx = IDX_W'(i);
            tgt_def = 1'b0;
         end
      end
   end

   always_comb begin
      s_HSEL = '0;
      for (int i = 0; i < SLAVES; i++)
         s_HSEL[i] = !tgt_def && (tgt_idx == IDX_W'(i));
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dsel_def_q <= 1'b1;
         dsel_idx_q <= '0;
      end else if (HREADY) begin
         dsel_def_q <= tgt_def;
         dsel_idx_q <= tgt_idx;
      end
   end

   always_comb begin
      HREADY = def_rdy;
      HRESP  = def_resp;
      HRDATA = '0;
      if (!dsel_def_q) begin
         for (int i = 0; i < SLAVES; i++) begin
            if (dsel_idx_q == IDX_W'(i)) begin
               HREADY = s_HREADYOUT[i];
               HRESP  = s_HRESP[i];
               HRDATA = s_HRDATA[i*HDATA_SIZE +: HDATA_SIZE];
            end
         end
      end
   end

   ahb3lite_default_slave #(
      .HADDR_SIZE (HADDR_SIZE)
   ) u_def (
      .hclk_i      (HCLK),
      .hreset_i    (HRESET),
      .hready_i    (HREADY),
      .sel_def_i   (tgt_def),
      .htrans_i    (HTRANS),
      .haddr_i     (HADDR),
      .err_clr_i   (err_clr),
      .hreadyout_o (def_rdy),
      .hresp_o     (def_resp),
      .err_addr_o  (err_addr),
      .err_count_o (err_count)
   );

endmodule

// File: tb/tb_ahb3lite_decoder_mux.sv
// Bench for ahb3lite_decoder_mux: directed scenarios plus random traffic against a transfer-level model.
module tb_ahb3lite_decoder_mux;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 4;
   localparam logic [NS*AW-1:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
   localparam logic [NS*AW-1:0] MASK = {4{32'hF000_0000}};

   logic             HCLK = 1'b0;
   logic             HRESET;
   logic [AW-1:0]    HADDR;
   logic [1:0]       HTRANS;
   logic             HREADY;
   logic             HRESP;
   logic [DW-1:0]    HRDATA;
   logic [NS-1:0]    s_HSEL;
   logic [NS-1:0]    s_HREADYOUT;
   logic [NS-1:0]    s_HRESP;
   logic [NS*DW-1:0] s_HRDATA;
   logic             err_clr;
   logic [AW-1:0]    err_addr;
   logic [7:0]       err_count;

   int checks = 0;
   int errors = 0;

   // Model: m_dsel = data-phase slave (-1 = default), m_ph = error cycles still to go (2, 1 or 0).
   int          m_dsel;
   int          m_ph;
   int          m_cnt;
   logic [31:0] m_addr;

   ahb3lite_decoder_mux #(
      .HADDR_SIZE (AW),
      .HDATA_SIZE (DW),
      .SLAVES     (NS),
      .SLAVE_BASE (BASE),
      .SLAVE_MASK (MASK)
   ) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .HRDATA      (HRDATA),
      .s_HSEL      (s_HSEL),
      .s_HREADYOUT (s_HREADYOUT),
      .s_HRESP     (s_HRESP),
      .s_HRDATA    (s_HRDATA),
      .err_clr     (err_clr),
      .err_addr    (err_addr),
      .err_count   (err_count)
   );

   always #5 HCLK = ~HCLK;

   // With this map the top address nibble is the slave number, nibbles 4..15 are unmapped.
   function automatic int tgt_of(input logic [31:0] a);
      int n;
      n = int'(a >> 28);
      return (n < NS) ? n : -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_dsel = -1;
      m_ph   = 0;
      m_cnt  = 0;
      m_addr = '0;
   endtask

   task automatic drive(input logic [31:0] a, input logic [1:0] t);
      HADDR  = a;
      HTRANS = t;
   endtask

   // Called at posedge+1; checks the current cycle, then advances model and DUT by one edge.
   task automatic tick();
      logic        e_rdy, e_resp;
      logic [31:0] e_rdata;
      logic [3:0]  e_sel;
      int          t;
      bit          err;
      s_HRDATA = {$urandom, $urandom, $urandom, $urandom};
      #3;
      t = tgt_of(HADDR);
      e_sel = (t >= 0) ? 4'(1 << t) : 4'b0000;
      if (m_dsel >= 0) begin
         e_rdy   = s_HREADYOUT[m_dsel];
         e_resp  = s_HRESP[m_dsel];
         e_rdata = s_HRDATA[m_dsel*32 +: 32];
      end else begin
         e_rdy   = (m_ph != 2);
         e_resp  = (m_ph != 0);
         e_rdata = '0;
      end
      chk("hready", HREADY, e_rdy);
      chk("hresp", HRESP, e_resp);
      chk("hrdata", HRDATA, e_rdata);
      chk("hsel", s_HSEL, e_sel);
      chk("err_addr", err_addr, m_addr);
      chk("err_count", err_count, m_cnt);
      @(posedge HCLK);
      if (HRESET) begin
         model_reset();
      end else begin
         err = 0;
         if (m_ph == 2) begin
            m_ph = 1;
         end else begin
            err  = e_rdy && (t < 0) && HTRANS[1];
            m_ph = err ? 2 : 0;
         end
         if (err) m_addr = HADDR;
         if (err_clr) m_cnt = err ? 1 : 0;
         else if (err && m_cnt < 255) m_cnt++;
         if (e_rdy) m_dsel = t;
      end
      #1;
   endtask

   initial begin
      HRESET = 1'b1;
      HADDR = '0;
      HTRANS = 2'b00;
      err_clr = 1'b0;
      s_HREADYOUT = '1;
      s_HRESP = '0;
      s_HRDATA = '0;
      repeat (2) @(posedge HCLK);
      #1;
      model_reset();
      HRESET = 1'b0;

      // Reset state
      chk("rst_hready", HREADY, 1'b1);
      chk("rst_hresp", HRESP, 1'b0);
      chk("rst_hrdata", HRDATA, 32'h0);
      chk("rst_errcnt", err_count, 8'd0);

      // Mapped read to slave 1
      drive(32'h1000_0040, 2'b10);
      tick();
      chk("sel_s1", s_HSEL, 4'b0010);
      chk("rd_s1", HRDATA, s_HRDATA[63:32]);
      drive(32'h0000_0000, 2'b00);
      tick();

      // Slave 2 wait states while the address moves to slave 3
      drive(32'h2000_0000, 2'b10);
      tick();
      s_HREADYOUT = 4'b1011;
      drive(32'h3000_0000, 2'b10);
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k < 2) begin
            chk("wait_rdy", HREADY, 1'b0);
            chk("wait_rdata", HRDATA, s_HRDATA[95:64]);
         end
      end
      s_HREADYOUT = 4'b1111;
      tick();
      drive(32'h0000_0000, 2'b00);
      tick();

      // Unmapped NONSEQ: ERR1, ERR2, IDLE
      drive(32'h8000_0000, 2'b10);
      tick();
      chk("err1_rdy", HREADY, 1'b0);
      chk("err1_resp", HRESP, 1'b1);
      chk("err_addr1", err_addr, 32'h8000_0000);
      chk("err_cnt1", err_count, 8'd1);
      drive(32'h0000_0000, 2'b00);
      tick();
      chk("err2_rdy", HREADY, 1'b1);
      chk("err2_resp", HRESP, 1'b1);
      tick();
      chk("idle_resp", HRESP, 1'b0);

      // IDLE transfer to unmapped space is a zero-wait OKAY
      drive(32'h8000_0000, 2'b00);
      tick();
      tick();
      chk("idle_unmapped_cnt", err_count, 8'd1);
      chk("idle_unmapped_rdy", HREADY, 1'b1);

      // 300 back-to-back unmapped SEQ transfers
      for (int k = 0; k < 600; k++) begin
         drive({4'($urandom_range(4, 15)), 28'($urandom)}, 2'b11);
         tick();
      end
      drive(32'h0000_0000, 2'b00);
      tick();
      tick();
      chk("sat_cnt", err_count, 8'd255);

      // Clear coinciding with a new error
      drive(32'h9000_0000, 2'b10);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_cnt", err_count, 8'd1);

      // Reset during ERR1
      drive(32'h0000_0000, 2'b00);
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      chk("rst_err1_rdy", HREADY, 1'b1);
      chk("rst_err1_resp", HRESP, 1'b0);
      chk("rst_err1_cnt", err_count, 8'd0);
      chk("rst_err1_rdata", HRDATA, 32'h0);
      tick();

      // Random traffic
      for (int k = 0; k < 500; k++) begin
         drive($urandom, 2'($urandom_range(0, 3)));
         err_clr = ($urandom_range(0, 15) == 0);
         HRESET = ($urandom_range(0, 63) == 0);
         s_HREADYOUT = 4'($urandom) | 4'($urandom);
         s_HRESP = 4'($urandom) & 4'($urandom);
         tick();
      end
      HRESET = 1'b0;
      err_clr = 1'b0;
      drive(32'h0000_0000, 2'b00);
      s_HREADYOUT = '1;
      s_HRESP = '0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
